// File: rtl/uart_pkg.sv
// Shared definitions for the UART arbiter family: FSM state encoding and default byte width.
package uart_pkg;
  localparam int UART_DATA_LENGTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_WAIT   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    // Scan farthest offset first so the nearest request after ptr overwrites.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        gnt_idx = IW'(j);
        any     = 1'b1;
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with per-owner message lock and an idle-lock timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_LENGTH  = UART_DATA_LENGTH,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW = $clog2(LOCK_TIMEOUT)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_valid,
  output logic [DATA_LENGTH-1:0]         tx_data,
  input  logic                           tx_done,
  output logic [IW-1:0]                  grant_id,
  output logic                           lock_active,
  output logic                           busy
);
  arb_state_t         state, state_nx;
  logic [IW-1:0]      rr_ptr;
  logic [TW-1:0]      tmo_cnt;
  logic [NUM_REQ-1:0] pk_onehot;
  logic [IW-1:0]      pk_idx;
  logic               pk_any;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               owner_valid;
  logic               hs;
  logic               tmo_run;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
    return (id == IW'(NUM_REQ - 1)) ? '0 : id + IW'(1);
  endfunction

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (pk_onehot),
    .gnt_idx    (pk_idx),
    .any        (pk_any)
  );

  // The lock owner is always the last served requester.
  assign owner_valid = req_valid[grant_id];

  always_comb begin
    win_idx = pk_idx;
    win_any = pk_any;
    if (lock_active) begin
      win_idx = grant_id;
      win_any = owner_valid;
    end
  end

  assign hs        = (state == ARB_IDLE) && win_any;
  assign req_ready = hs ? (NUM_REQ'(1) << win_idx) : '0;
  assign tmo_run   = (state == ARB_IDLE) && lock_active && !owner_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE:   if (hs) state_nx = ARB_LAUNCH;
      ARB_LAUNCH: state_nx = ARB_WAIT;
      ARB_WAIT:   if (tx_done) state_nx = ARB_IDLE;
      default:    state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      lock_active <= 1'b0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
    end else begin
      tx_valid <= (state_nx == ARB_LAUNCH);
      busy     <= (state_nx != ARB_IDLE);
      if (hs) begin
        tx_data     <= req_data[int'(win_idx)*DATA_LENGTH +: DATA_LENGTH];
        grant_id    <= win_idx;
        lock_active <= req_lock[win_idx];
        tmo_cnt     <= '0;
      end else if (tmo_run) begin
        if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
          lock_active <= 1'b0;
          rr_ptr      <= next_ptr(grant_id);
          tmo_cnt     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
      if (state == ARB_WAIT && tx_done && !lock_active) rr_ptr <= next_ptr(grant_id);
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus fairness, lock, timeout and reset sequences.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DL = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] req_valid;
  logic [NR*DL-1:0] req_data;
  logic [NR-1:0] req_lock;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [DL-1:0] tx_data;
  logic          tx_done;
  logic [1:0]    grant_id;
  logic          lock_active;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_LENGTH(DL), .LOCK_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .lock_active (lock_active),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  lock;
    logic        done;
    logic [3:0]  rdy;
    logic        txv;
    logic        bsy;
    logic        lk;
    logic [1:0]  gid;
    logic [7:0]  txd;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    tx_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a launch; leaves time at the negedge of the launch cycle.
  task automatic wait_launch(input string name);
    int n = 0;
    @(negedge clk);
    while (!tx_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, tx_valid, 1);
  endtask

  initial begin
    // valid, data, lock, done | ready, tx_valid, busy, lock_active, grant_id, tx_data
    vt[0]  = '{4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[1]  = '{4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[2]  = '{4'h4, 32'h00A50000, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vt[3]  = '{4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 2'd2, 8'hA5};
    vt[4]  = '{4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA5};
    vt[5]  = '{4'h4, 32'h00A50000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA5};
    vt[6]  = '{4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA5};
    vt[7]  = '{4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 8'hA5};
    vt[8]  = '{4'hC, 32'h3C200000, 4'h0, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 2'd2, 8'hA5};
    vt[9]  = '{4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd3, 8'h3C};
    vt[10] = '{4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 2'd3, 8'h3C};
    vt[11] = '{4'h9, 32'h77000044, 4'h0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h3C};
    vt[12] = '{4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h44};
    vt[13] = '{4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h44};
    vt[14] = '{4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h44};

    // Single byte, spurious tx_done, rr_ptr advance and wrap.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req_valid = vt[i].valid;
      req_data  = vt[i].data;
      req_lock  = vt[i].lock;
      tx_done   = vt[i].done;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), req_ready, vt[i].rdy);
      check($sformatf("vec%0d_txv", i), tx_valid, vt[i].txv);
      check($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      check($sformatf("vec%0d_lock", i), lock_active, vt[i].lk);
      check($sformatf("vec%0d_gid", i), grant_id, vt[i].gid);
      check($sformatf("vec%0d_txd", i), tx_data, vt[i].txd);
      next_cycle();
    end

    // Fairness: everyone valid, frames complete 20 cycles after launch.
    do_reset();
    req_valid = 4'hF;
    req_data  = 32'hA3A2A1A0;
    for (int g = 0; g < 5; g++) begin
      wait_launch("fair_launch");
      check("fair_gid", grant_id, g % 4);
      check("fair_data", tx_data, 8'hA0 + (g % 4));
      for (int c = 1; c < 20; c++) begin
        @(negedge clk);
        check("fair_no_relaunch", tx_valid, 0);
        check("fair_busy", busy, 1);
      end
      next_cycle();
      tx_done = 1'b1;
      next_cycle();
      tx_done = 1'b0;
    end

    // Lock burst from requester 1 while requester 0 waits.
    do_reset();
    req_valid = 4'h2;
    req_data  = 32'h00001100;
    req_lock  = 4'h2;
    begin
      logic [7:0]  exp_d[4]   = '{8'h11, 8'h22, 8'h33, 8'h55};
      logic        exp_lk[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0]  exp_rdy[4] = '{4'h2, 4'h2, 4'h1, 4'h0};
      logic [3:0]  nv[4]      = '{4'h3, 4'h3, 4'h1, 4'h0};
      logic [31:0] nd[4]      = '{32'h00002255, 32'h00003355, 32'h00000055, 32'h0};
      logic [3:0]  nl[4]      = '{4'h2, 4'h0, 4'h0, 4'h0};
      for (int b = 0; b < 4; b++) begin
        wait_launch("lock_launch");
        check("lock_wire_data", tx_data, exp_d[b]);
        check("lock_active", lock_active, exp_lk[b]);
        next_cycle();
        req_valid = nv[b];
        req_data  = nd[b];
        req_lock  = nl[b];
        next_cycle();
        tx_done = 1'b1;
        next_cycle();
        tx_done = 1'b0;
        @(negedge clk);
        check("lock_ready", req_ready, exp_rdy[b]);
      end
    end

    // Idle-lock timeout: owner 3 drops valid, requester 0 waits 16 cycles.
    do_reset();
    req_valid = 4'h8;
    req_data  = 32'h3D000000;
    req_lock  = 4'h8;
    wait_launch("tmo_launch");
    next_cycle();
    req_valid = 4'h1;
    req_data  = 32'h0000000A;
    req_lock  = 4'h0;
    tx_done   = 1'b1;
    next_cycle();
    tx_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tmo_hold_ready", req_ready, 4'h0);
      check("tmo_hold_lock", lock_active, 1);
      check("tmo_hold_busy", busy, 0);
    end
    @(negedge clk);
    check("tmo_lock_dropped", lock_active, 0);
    check("tmo_ready0", req_ready, 4'h1);
    @(negedge clk);
    check("tmo_launch0", tx_valid, 1);
    check("tmo_data0", tx_data, 8'h0A);
    check("tmo_gid0", grant_id, 0);

    // Reset mid-frame, then a stray tx_done.
    do_reset();
    req_valid = 4'h4;
    req_data  = 32'h005A0000;
    req_lock  = 4'h4;
    wait_launch("rst_launch");
    next_cycle();
    req_valid = 4'h0;
    @(negedge clk);
    check("rst_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_lock", lock_active, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    next_cycle();
    reset_n = 1'b1;
    tx_done = 1'b1;
    next_cycle();
    tx_done   = 1'b0;
    req_valid = 4'h2;
    @(negedge clk);
    check("rst_stray_busy", busy, 0);
    check("rst_stray_txv", tx_valid, 0);
    check("rst_after_ready", req_ready, 4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
